// File: rtl/rx_mac_interface_if.sv
// Signal bundle for rx_mac_interface: MAC RX stream, buffer write port, commit/read pointers, stats.
// Address width is `BF+1 (defaults to 9 here, giving a 10-bit address).
`ifndef BF
`define BF 9
`endif

interface rx_mac_interface_if;
  logic [63:0]  rx_data;
  logic [7:0]   rx_data_valid;
  logic         rx_good_frame;
  logic         rx_bad_frame;
  logic [`BF:0] wr_addr;
  logic [63:0]  wr_data;
  logic         wr_en;
  logic [`BF:0] commited_wr_addr;
  logic         commited_wr_addr_change;
  logic [`BF:0] commited_rd_addr;
  logic         rd_addr_updated;
  logic [31:0]  frames_received;
  logic [31:0]  frames_dropped;

  modport master (
    output rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
    output commited_rd_addr, rd_addr_updated,
    input  wr_addr, wr_data, wr_en, commited_wr_addr, commited_wr_addr_change,
    input  frames_received, frames_dropped
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
    input  commited_rd_addr, rd_addr_updated,
    output wr_addr, wr_data, wr_en, commited_wr_addr, commited_wr_addr_change,
    output frames_received, frames_dropped
  );
endinterface

// File: rtl/rx_mac_interface.sv
// MAC RX qword stream into a ring buffer: header qword at sof, data from sof+1, commit on good end.
// Define RX_MAC_STATS_EN to build the frames_received / frames_dropped counters.
`ifndef BF
`define BF 9
`endif

module rx_mac_interface (
  input  logic             clk,
  input  logic             reset_n,
  rx_mac_interface_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for first data cycle of a frame
  // FRAME  | writing data qwords, counting bytes
  // HEADER | writing header at sof, advancing write pointer
  // DROP   | frame abandoned, waiting for its end pulse
  localparam int AW = `BF + 1;

  typedef enum logic [1:0] {IDLE, FRAME, HEADER, DROP} state_t;
  state_t state, state_nx;

  // wr_ptr stays at sof for the whole frame, so rewinding simply means not moving it
  logic [AW-1:0] wr_ptr, next_addr, wr_target, rd_addr_q, rd_ptr;
  logic [AW-1:0] wr_addr, commited_wr_addr;
  logic [63:0]   wr_data;
  logic          wr_en, commit_chg;
  logic          rd_upd_s1, rd_upd_s2;
  logic [31:0]   byte_cnt;
  logic [9:0]    qcnt;
  logic [3:0]    pop;
  logic          data_cyc, ovf, start, do_write, commit, rewind, hdr_write;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) pop = pop + {3'b000, bus.rx_data_valid[i]};
  end

  assign data_cyc = |bus.rx_data_valid;

  always_comb begin
    state_nx  = state;
    wr_target = next_addr;
    ovf       = 1'b0;
    start     = 1'b0;
    do_write  = 1'b0;
    commit    = 1'b0;
    rewind    = 1'b0;
    hdr_write = 1'b0;
    case (state)
      IDLE, FRAME: begin
        if (state == FRAME || data_cyc) begin
          if (state == IDLE) begin
            start     = 1'b1;
            wr_target = wr_ptr + 1'b1;
          end
          ovf      = data_cyc && ((wr_target == rd_ptr) || (state == FRAME && qcnt == 10'h3FF));
          do_write = data_cyc && !ovf && !bus.rx_bad_frame;
          if (bus.rx_bad_frame || (bus.rx_good_frame && ovf)) begin
            rewind   = 1'b1;
            state_nx = IDLE;
          end else if (bus.rx_good_frame) begin
            commit   = 1'b1;
            state_nx = HEADER;
          end else if (ovf) begin
            state_nx = DROP;
          end else begin
            state_nx = FRAME;
          end
        end
      end
      HEADER: begin
        hdr_write = 1'b1;
        state_nx  = IDLE;
      end
      DROP: begin
        if (bus.rx_good_frame || bus.rx_bad_frame) begin
          rewind   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      next_addr        <= '0;
      wr_addr          <= '0;
      wr_data          <= '0;
      wr_en            <= 1'b0;
      commited_wr_addr <= '0;
      commit_chg       <= 1'b0;
      byte_cnt         <= '0;
      qcnt             <= '0;
    end else begin
      state      <= state_nx;
      wr_en      <= do_write | hdr_write;
      commit_chg <= (state == HEADER);
      if (do_write) begin
        wr_addr   <= wr_target;
        wr_data   <= bus.rx_data;
        next_addr <= wr_target + 1'b1;
        qcnt      <= start ? 10'd1 : qcnt + 10'd1;
        byte_cnt  <= (start ? 32'd0 : byte_cnt) + {28'd0, pop};
      end
      // commit is published on the status edge; the header lands one cycle later
      if (commit) commited_wr_addr <= do_write ? wr_target + 1'b1 : next_addr;
      if (hdr_write) begin
        wr_addr <= wr_ptr;
        wr_data <= {byte_cnt, 32'd0};
        wr_ptr  <= commited_wr_addr;
      end
      if (rewind) wr_addr <= wr_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_upd_s1 <= 1'b0;
      rd_upd_s2 <= 1'b0;
      rd_addr_q <= '0;
      rd_ptr    <= '0;
    end else begin
      rd_upd_s1 <= bus.rd_addr_updated;
      rd_upd_s2 <= rd_upd_s1;
      rd_addr_q <= bus.commited_rd_addr;
      if (rd_upd_s2) rd_ptr <= rd_addr_q;
    end
  end

  assign bus.wr_addr                 = wr_addr;
  assign bus.wr_data                 = wr_data;
  assign bus.wr_en                   = wr_en;
  assign bus.commited_wr_addr        = commited_wr_addr;
  assign bus.commited_wr_addr_change = commit_chg;

`ifdef RX_MAC_STATS_EN
  logic [31:0] rx_cnt, drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit) rx_cnt <= rx_cnt + 32'd1;
      if (rewind) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign bus.frames_received = rx_cnt;
  assign bus.frames_dropped  = drop_cnt;
`else
  assign bus.frames_received = '0;
  assign bus.frames_dropped  = '0;
`endif
endmodule

// File: doc/rx_mac_interface.md
RX_MAC_INTERFACE -- requirements
Module: rx_mac_interface

Interface
REQ-001 clk  in  1  single clock, MAC RX domain; reset is asynchronous and active-low.
REQ-002 reset_n  in  1  asynchronous active-low reset.
REQ-003 rx_data  in  64  MAC RX data qword; byte 0 in bits [7:0].
REQ-004 rx_data_valid  in  8  byte-lane valid mask, contiguous from bit 0; nonzero marks a data cycle.
REQ-005 rx_good_frame  in  1  one-cycle pulse, frame ended OK; may coincide with the last data cycle.
REQ-006 rx_bad_frame  in  1  one-cycle pulse, frame ended with error; same timing as rx_good_frame.
REQ-007 wr_addr  out  `BF+1  internal buffer write address.
REQ-008 wr_data  out  64  internal buffer write data.
REQ-009 wr_en  out  1  buffer write strobe, one qword per cycle.
REQ-010 commited_wr_addr  out  `BF+1  first free address after the last committed frame; 250 MHz consumer.
REQ-011 commited_wr_addr_change  out  1  one-cycle pulse, exactly one cycle after commited_wr_addr changes.
REQ-012 commited_rd_addr  in  `BF+1  consumer read pointer; 250 MHz domain driven.
REQ-013 rd_addr_updated  in  1  qualifier for commited_rd_addr; 250 MHz domain driven.
REQ-014 frames_received  out  32  good frames committed.
REQ-015 frames_dropped  out  32  bad, overflowed or oversize frames.

Function
REQ-016 rd_addr_updated SHALL pass through a 2-flop synchronizer; commited_rd_addr SHALL be registered, then captured into the local read pointer only while the synchronized qualifier is high.
REQ-017 Frame layout in the buffer SHALL be one header qword at sof, then data qwords at sof+1 onward; header [63:32] = byte count, [31:0] = 0.
REQ-018 FSM states: IDLE, FRAME, HEADER, DROP.
REQ-019 IDLE: first cycle with rx_data_valid nonzero latches sof = write pointer, writes the qword to sof+1, clears the byte counter and moves to FRAME.
REQ-020 FRAME: each data cycle writes to the next address and adds the popcount of rx_data_valid to the 32-bit byte counter.
REQ-021 Overflow: a data write whose target equals the local read pointer SHALL be suppressed and the state SHALL go to DROP.
REQ-022 Oversize: when the qword count exceeds 1023 (10-bit field), the state SHALL go to DROP.
REQ-023 rx_good_frame in FRAME SHALL move the state to HEADER; a data qword valid in the same cycle SHALL be included in the frame.
REQ-024 HEADER: one cycle; SHALL write the header at sof, set the write pointer to sof+qwords+1, set commited_wr_addr to the same value, pulse commited_wr_addr_change the next cycle and return to IDLE.
REQ-025 rx_bad_frame in FRAME, or any frame end in DROP, SHALL rewind the write pointer to sof, write no header, leave commited_wr_addr unchanged, increment frames_dropped and return to IDLE.
REQ-026 DROP SHALL ignore data and SHALL issue no writes.
REQ-027 All address arithmetic SHALL be modulo 2^(`BF+1); frames SHALL wrap through the top of the buffer.
REQ-028 The MAC guarantees at least 3 idle cycles between a frame end and the next data; behaviour is undefined otherwise.
REQ-029 Latency: the first data qword SHALL be written the cycle after it is presented; commit occurs 1 cycle after the status pulse, and the change pulse 2 cycles after it.

Reset
REQ-030 On reset_n low: wr_addr, wr_data, wr_en, commited_wr_addr, commited_wr_addr_change, counters, the local read pointer and the synchronizer flops SHALL be 0; FSM SHALL be IDLE.
REQ-031 Deassertion mid-frame: the remaining frame data SHALL be treated as a new frame start; no recovery is attempted.

Configuration
REQ-032 With RX_MAC_STATS_EN defined, frames_received and frames_dropped SHALL count as specified, wrapping at 2^32.
REQ-033 Without RX_MAC_STATS_EN, both outputs SHALL be constant 0 and no counter registers SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-034 64-byte good frame at empty buffer -> data at 1..8, header 0x00000040_00000000 at 0, commited_wr_addr=9 and one pulse.
REQ-035 61-byte frame, last mask 0x1F -> header byte count 61, 8 data qwords, commited_wr_addr=9.
REQ-036 Bad frame after one good frame -> wr_addr rewound to 9, commited_wr_addr stays 9, frames_dropped=1.
REQ-037 Read pointer at 20 and write pointer at 9, 128-byte frame -> overflow, no write at 20, rewind to 9, frame dropped.
REQ-038 Write pointer at 2^(`BF+1)-3 with a 64-byte frame and free space -> wrapped writes, commited_wr_addr = 6.
REQ-039 rx_good_frame coincident with last data qword -> qword included, header count correct.
